// File: rtl/wb_dec_pkg.sv
// Shared types and constants for the N-slave Wishbone decoder.
// sel_index() is a priority encoder in which the lowest set hit bit wins.
package wb_dec_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } wb_dec_state_t;

   localparam int unsigned MAX_SLV = 8;
   localparam int unsigned SEL_W   = 3;

   localparam logic [31:0] ERR_DATA_DEF  = 32'hDEAD_BEEF;
   localparam logic [31:0] MPRJ_MASK_DEF = 32'hFFFF_F000;

   function automatic logic [SEL_W-1:0] sel_index(input logic [MAX_SLV-1:0] hit);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = MAX_SLV - 1; i >= 0; i--) begin
         if (hit[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Cycle counter that runs while en is high. expired pulses for one cycle
// when the count reaches LIMIT-1, and the count then wraps to zero.
module wb_timeout_cnt #(
   parameter int unsigned W     = 16,
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [W-1:0] cnt;

   assign expired = en && (cnt == W'(LIMIT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= expired ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/wb_slave_decoder_n.sv
// N-slave Wishbone decoder/router with a registered response, a bus-timeout
// watchdog, error responses, and a sticky error log.
module wb_slave_decoder_n
   import wb_dec_pkg::*;
#(
   parameter int unsigned          N_SLV      = 4,
   parameter int unsigned          DATA_W     = 32,
   parameter logic [31:0]          ADDR_MASK  = MPRJ_MASK_DEF,
   parameter logic [N_SLV*32-1:0]  BASE_ADDRS = '0,
   parameter int unsigned          TIMEOUT    = 255,
   parameter logic [DATA_W-1:0]    ERR_DATA   = DATA_W'(ERR_DATA_DEF)
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic                      wbs_cyc_i,
   input  logic                      wbs_stb_i,
   input  logic [31:0]               wbs_adr_i,
   output logic [DATA_W-1:0]         wbs_dat_o,
   output logic                      wbs_ack_o,
   output logic [N_SLV-1:0]          s_cyc_o,
   output logic [N_SLV-1:0]          s_stb_o,
   input  logic [N_SLV-1:0]          s_ack_i,
   input  logic [N_SLV*DATA_W-1:0]   s_dat_i,
   input  logic                      err_clr_i,
   output logic                      err_irq_o,
   output logic [31:0]               err_adr_o,
   output logic [7:0]                err_cnt_o
);

   localparam int unsigned CNT_W = 16;

   wb_dec_state_t     state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              err_wait_q, err_wait_d;
   logic [DATA_W-1:0] dat_d;
   logic              ack_d;
   logic              err_log;
   logic              tmo_clr;
   logic              tmo_expired;
   logic              busy;

   logic [MAX_SLV-1:0] hit;
   logic               any_hit;
   logic [SEL_W-1:0]   hit_idx;
   logic               sel_ack;
   logic [DATA_W-1:0]  sel_dat;

   assign busy = (state_q == BUSY);

   // Address decode over the masked region
   always_comb begin
      hit = '0;
      for (int k = 0; k < N_SLV; k++) begin
         hit[k] = ((wbs_adr_i & ADDR_MASK) == BASE_ADDRS[k*32 +: 32]);
      end
      any_hit = |hit;
      hit_idx = sel_index(hit);
   end

   // Selected-slave response mux and gated slave handshakes
   always_comb begin
      sel_ack = 1'b0;
      sel_dat = '0;
      s_cyc_o = '0;
      s_stb_o = '0;
      for (int k = 0; k < N_SLV; k++) begin
         if (sel_q == SEL_W'(k)) begin
            sel_ack    = s_ack_i[k];
            sel_dat    = s_dat_i[k*DATA_W +: DATA_W];
            s_cyc_o[k] = busy && wbs_cyc_i;
            s_stb_o[k] = busy && wbs_stb_i;
         end
      end
   end

   wb_timeout_cnt #(
      .W     (CNT_W),
      .LIMIT (TIMEOUT)
   ) u_tmo (
      .clk     (wb_clk_i),
      .rst     (wb_rst_i),
      .clr     (tmo_clr),
      .en      (busy),
      .expired (tmo_expired)
   );

   // Error responses spend one extra RESP cycle (err_wait) before the ack
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      err_wait_d = 1'b0;
      dat_d      = wbs_dat_o;
      ack_d      = 1'b0;
      err_log    = 1'b0;
      tmo_clr    = 1'b0;
      case (state_q)
         IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               if (any_hit) begin
                  sel_d   = hit_idx;
                  tmo_clr = 1'b1;
                  state_d = BUSY;
               end else begin
                  dat_d      = ERR_DATA;
                  err_log    = 1'b1;
                  err_wait_d = 1'b1;
                  state_d    = RESP;
               end
            end
         end
         BUSY: begin
            if (!wbs_cyc_i) begin
               state_d = IDLE;
            end else if (sel_ack) begin
               dat_d   = sel_dat;
               ack_d   = 1'b1;
               state_d = RESP;
            end else if (tmo_expired) begin
               dat_d      = ERR_DATA;
               err_log    = 1'b1;
               err_wait_d = 1'b1;
               state_d    = RESP;
            end
         end
         RESP: begin
            if (err_wait_q) begin
               ack_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         err_wait_q <= 1'b0;
         wbs_dat_o  <= '0;
         wbs_ack_o  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         err_wait_q <= err_wait_d;
         wbs_dat_o  <= dat_d;
         wbs_ack_o  <= ack_d;
      end
   end

   // Sticky error log; a new error outranks a simultaneous clear
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         err_irq_o <= 1'b0;
         err_adr_o <= '0;
         err_cnt_o <= '0;
      end else if (err_log) begin
         err_irq_o <= 1'b1;
         err_adr_o <= wbs_adr_i;
         if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      end else if (err_clr_i) begin
         err_irq_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_slave_decoder_n.sv
// Directed bench for wb_slave_decoder_n: two slaves at 0x3000_0000 and
// 0x3100_0000, timeout of 8 cycles.
module tb_wb_slave_decoder_n;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc, stb, err_clr;
   logic [31:0] adr;
   logic [31:0] dat;
   logic        ack;
   logic [1:0]  s_cyc, s_stb, s_ack;
   logic [63:0] s_dat;
   logic        irq;
   logic [31:0] eadr;
   logic [7:0]  ecnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_slave_decoder_n #(
      .N_SLV      (2),
      .DATA_W     (32),
      .BASE_ADDRS (64'h3100_0000_3000_0000),
      .TIMEOUT    (8)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_cyc_i (cyc),
      .wbs_stb_i (stb),
      .wbs_adr_i (adr),
      .wbs_dat_o (dat),
      .wbs_ack_o (ack),
      .s_cyc_o   (s_cyc),
      .s_stb_o   (s_stb),
      .s_ack_i   (s_ack),
      .s_dat_i   (s_dat),
      .err_clr_i (err_clr),
      .err_irq_o (irq),
      .err_adr_o (eadr),
      .err_cnt_o (ecnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one access; the request appears in cycle 0 and the slave acks in
   // BUSY cycle ack_after+1 (never if ack_after < 0). Returns observations only.
   task automatic run_access(input logic [31:0] a, input int ack_after, input int slv,
                             input logic [31:0] d, input logic clr0,
                             output int ack_cyc, output logic [31:0] rd,
                             output int stb_cycles, output logic [1:0] stb_seen);
      ack_cyc    = -1;
      rd         = '0;
      stb_cycles = 0;
      stb_seen   = '0;
      step();
      cyc = 1'b1; stb = 1'b1; adr = a; err_clr = clr0; s_ack = '0;
      for (int c = 1; c <= 40; c++) begin
         step();
         err_clr = 1'b0;
         s_ack   = (ack_after >= 0 && c == ack_after + 1) ? 2'(1 << slv) : 2'b00;
         s_dat   = (slv == 0) ? {32'hAAAA_AAAA, d} : {d, 32'h5555_5555};
         #1;
         if (s_stb != 2'b00) stb_cycles++;
         stb_seen |= s_stb;
         if (ack) begin
            ack_cyc = c;
            rd      = dat;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; s_ack = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; adr = '0; err_clr = 1'b0;
      s_ack = '0; s_dat = '0;
      step(); step();
      checks++;
      if (ack !== 1'b0 || dat !== 32'h0) begin
         errors++; $display("FAIL reset_resp: ack=%b dat=%h expected 0/00000000", ack, dat);
      end
      checks++;
      if (s_cyc !== 2'b00 || s_stb !== 2'b00) begin
         errors++; $display("FAIL reset_slv: cyc=%b stb=%b expected 00/00", s_cyc, s_stb);
      end
      checks++;
      if (irq !== 1'b0 || eadr !== 32'h0 || ecnt !== 8'h0) begin
         errors++; $display("FAIL reset_err: irq=%b adr=%h cnt=%0d expected 0/0/0", irq, eadr, ecnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_read_slave0();
      int ac, sc; logic [31:0] rd; logic [1:0] ss;
      run_access(32'h3000_0004, 1, 0, 32'h1234_5678, 1'b0, ac, rd, sc, ss);
      checks++;
      if (ac != 3) begin errors++; $display("FAIL rd0_latency: got %0d expected 3", ac); end
      checks++;
      if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rd0_data: got %h expected 12345678", rd); end
      checks++;
      if (ss !== 2'b01 || sc != 2) begin
         errors++; $display("FAIL rd0_stb: seen=%b cycles=%0d expected 01/2", ss, sc);
      end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL rd0_irq: got %b expected 0", irq); end
      step();
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL rd0_ack_pulse: got %b expected 0", ack); end
   endtask

   task automatic test_write_slave1();
      int ac, sc; logic [31:0] rd; logic [1:0] ss;
      run_access(32'h3100_0008, 0, 1, 32'hCAFE_F00D, 1'b0, ac, rd, sc, ss);
      checks++;
      if (ac != 2) begin errors++; $display("FAIL wr1_latency: got %0d expected 2", ac); end
      checks++;
      if (ss !== 2'b10 || sc != 1) begin
         errors++; $display("FAIL wr1_stb: seen=%b cycles=%0d expected 10/1", ss, sc);
      end
      checks++;
      if (irq !== 1'b0 || ecnt !== 8'd0) begin
         errors++; $display("FAIL wr1_noerr: irq=%b cnt=%0d expected 0/0", irq, ecnt);
      end
   endtask

   task automatic test_unmapped();
      int ac, sc; logic [31:0] rd; logic [1:0] ss;
      run_access(32'h3200_0000, -1, 0, 32'h0, 1'b0, ac, rd, sc, ss);
      checks++;
      if (ac != 2) begin errors++; $display("FAIL unm_latency: got %0d expected 2", ac); end
      checks++;
      if (rd !== 32'hDEAD_BEEF || sc != 0) begin
         errors++; $display("FAIL unm_resp: dat=%h stb_cycles=%0d expected deadbeef/0", rd, sc);
      end
      checks++;
      if (irq !== 1'b1 || eadr !== 32'h3200_0000 || ecnt !== 8'd1) begin
         errors++; $display("FAIL unm_log: irq=%b adr=%h cnt=%0d expected 1/32000000/1", irq, eadr, ecnt);
      end
   endtask

   task automatic test_timeout();
      int ac, sc; logic [31:0] rd; logic [1:0] ss;
      run_access(32'h3000_0010, -1, 0, 32'h0, 1'b0, ac, rd, sc, ss);
      checks++;
      if (ac != 10) begin errors++; $display("FAIL tmo_latency: got %0d expected 10", ac); end
      checks++;
      if (sc != 8 || ss !== 2'b01) begin
         errors++; $display("FAIL tmo_stb: cycles=%0d seen=%b expected 8/01", sc, ss);
      end
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tmo_data: got %h expected deadbeef", rd); end
      checks++;
      if (ecnt !== 8'd2 || eadr !== 32'h3000_0010 || irq !== 1'b1) begin
         errors++; $display("FAIL tmo_log: cnt=%0d adr=%h irq=%b expected 2/30000010/1", ecnt, eadr, irq);
      end
   endtask

   task automatic test_err_clr();
      int ac, sc; logic [31:0] rd; logic [1:0] ss;
      step(); err_clr = 1'b1;
      step(); err_clr = 1'b0;
      checks++;
      if (irq !== 1'b0 || ecnt !== 8'd2 || eadr !== 32'h3000_0010) begin
         errors++; $display("FAIL clr_alone1: irq=%b cnt=%0d adr=%h expected 0/2/30000010", irq, ecnt, eadr);
      end
      run_access(32'h3300_0000, -1, 0, 32'h0, 1'b1, ac, rd, sc, ss);
      checks++;
      if (irq !== 1'b1 || ecnt !== 8'd3 || eadr !== 32'h3300_0000) begin
         errors++; $display("FAIL clr_set_wins: irq=%b cnt=%0d adr=%h expected 1/3/33000000", irq, ecnt, eadr);
      end
      step(); err_clr = 1'b1;
      step(); err_clr = 1'b0;
      checks++;
      if (irq !== 1'b0 || ecnt !== 8'd3) begin
         errors++; $display("FAIL clr_alone2: irq=%b cnt=%0d expected 0/3", irq, ecnt);
      end
   endtask

   task automatic test_ignored_ack();
      int seen;
      seen = 0;
      step(); s_ack = 2'b11;
      for (int i = 0; i < 3; i++) begin
         step();
         if (ack) seen++;
      end
      s_ack = 2'b00;
      checks++;
      if (seen != 0 || dat !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL idle_ack: acks=%0d dat=%h expected 0/deadbeef", seen, dat);
      end
      step(); cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0000;
      s_dat = {32'h1111_1111, 32'h2222_2222};
      step(); s_ack = 2'b10;
      #1;
      checks++;
      if (s_stb !== 2'b01) begin errors++; $display("FAIL wrong_ack_stb: got %b expected 01", s_stb); end
      step(); s_ack = 2'b01;
      step(); s_ack = 2'b00;
      #1;
      checks++;
      if (ack !== 1'b1 || dat !== 32'h2222_2222) begin
         errors++; $display("FAIL wrong_ack_resp: ack=%b dat=%h expected 1/22222222", ack, dat);
      end
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic test_abort();
      int seen, ac, sc; logic [31:0] rd; logic [1:0] ss;
      seen = 0;
      step(); cyc = 1'b1; stb = 1'b1; adr = 32'h3000_0000;
      step(); #1;
      checks++;
      if (s_cyc !== 2'b01) begin errors++; $display("FAIL abort_busy_cyc: got %b expected 01", s_cyc); end
      step(); cyc = 1'b0; stb = 1'b0; #1;
      checks++;
      if (s_cyc !== 2'b00 || s_stb !== 2'b00) begin
         errors++; $display("FAIL abort_gate: cyc=%b stb=%b expected 00/00", s_cyc, s_stb);
      end
      for (int i = 0; i < 12; i++) begin
         step();
         if (ack) seen++;
      end
      checks++;
      if (seen != 0 || ecnt !== 8'd3) begin
         errors++; $display("FAIL abort_noack: acks=%0d cnt=%0d expected 0/3", seen, ecnt);
      end
      run_access(32'h3100_0000, 0, 1, 32'h0BAD_F00D, 1'b0, ac, rd, sc, ss);
      checks++;
      if (ac != 2 || rd !== 32'h0BAD_F00D) begin
         errors++; $display("FAIL abort_next: lat=%0d dat=%h expected 2/0badf00d", ac, rd);
      end
   endtask

   task automatic test_reset_mid_busy();
      int seen;
      seen = 0;
      step(); cyc = 1'b1; stb = 1'b1; adr = 32'h3100_0004;
      step(); #1;
      checks++;
      if (s_stb !== 2'b10) begin errors++; $display("FAIL rstb_busy_stb: got %b expected 10", s_stb); end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (s_cyc !== 2'b00 || s_stb !== 2'b00 || ack !== 1'b0 || dat !== 32'h0) begin
         errors++; $display("FAIL rstb_outputs: cyc=%b stb=%b ack=%b dat=%h expected 00/00/0/0", s_cyc, s_stb, ack, dat);
      end
      checks++;
      if (irq !== 1'b0 || eadr !== 32'h0 || ecnt !== 8'h0) begin
         errors++; $display("FAIL rstb_err: irq=%b adr=%h cnt=%0d expected 0/0/0", irq, eadr, ecnt);
      end
      cyc = 1'b0; stb = 1'b0;
      step(); rst = 1'b0;
      s_ack = 2'b10; s_dat = {32'h7777_7777, 32'h0};
      for (int i = 0; i < 3; i++) begin
         step();
         if (ack) seen++;
      end
      s_ack = 2'b00;
      checks++;
      if (seen != 0 || dat !== 32'h0) begin
         errors++; $display("FAIL rstb_late_ack: acks=%0d dat=%h expected 0/0", seen, dat);
      end
   endtask

   task automatic test_saturation();
      int ac, sc; logic [31:0] rd; logic [1:0] ss;
      for (int i = 0; i < 254; i++) run_access(32'h3400_0000, -1, 0, 32'h0, 1'b0, ac, rd, sc, ss);
      checks++;
      if (ecnt !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", ecnt); end
      for (int i = 0; i < 6; i++) run_access(32'h3400_0000, -1, 0, 32'h0, 1'b0, ac, rd, sc, ss);
      checks++;
      if (ecnt !== 8'd255) begin errors++; $display("FAIL sat_260: got %0d expected 255", ecnt); end
   endtask

   initial begin
      test_reset();
      test_read_slave0();
      test_write_slave1();
      test_unmapped();
      test_timeout();
      test_err_clr();
      test_ignored_ack();
      test_abort();
      test_reset_mid_busy();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
